product_accumulator: RTL and testbench

- Downstream stage of the signed/unsigned multiplier; accumulates a group of 2n-bit products into one sum (dot-product / MAC tail).
- Each product beat carries its own signedness flag and a group-end marker.
- Valid/ready on both sides; holds the finished sum until the consumer accepts it.
- Reports overflow, signedness mismatch and forced truncation per group.

---
 rtl/product_acc_pkg.sv | 18 +
 rtl/product_acc_adder.sv | 28 ++
 rtl/product_accumulator.sv | 115 +++++++++++
 tb/tb_product_accumulator.sv | 188 ++++++++++++++++++
 4 files changed

// File: rtl/product_acc_pkg.sv
// Shared types and sizing helpers for the product accumulator slice.
package product_acc_pkg;

    typedef enum logic [1:0] {
        IDLE,
        ACCUM,
        DONE
    } state_t;

    function automatic int count_width(input int max_terms);
        return $clog2(max_terms + 1);
    endfunction

    function automatic int acc_width(input int n, input int guard);
        return 2 * n + guard;
    endfunction

endpackage

// File: rtl/product_acc_adder.sv
// Combinational extend-and-add of one product into the running accumulator,
// with overflow judged under the requested signedness.
module product_acc_adder
    import product_acc_pkg::*;
#(
    parameter int n = 8,
    parameter int guard = 8,
    localparam int W = acc_width(n, guard)
) (
    input  logic [W-1:0]   acc,
    input  logic [2*n-1:0] product,
    input  logic           is_signed,
    output logic [W-1:0]   sum,
    output logic           overflow
);

    logic [W-1:0] ext;
    logic [W:0]   full;

    // Signed overflow: like-signed operands producing an opposite-signed result.
    always_comb begin
        ext      = is_signed ? {{guard{product[2*n-1]}}, product} : {{guard{1'b0}}, product};
        full     = {1'b0, acc} + {1'b0, ext};
        sum      = full[W-1:0];
        overflow = is_signed ? ((acc[W-1] == ext[W-1]) && (sum[W-1] != acc[W-1])) : full[W];
    end

endmodule

// File: rtl/product_accumulator.sv
// Accumulates a group of multiplier products into one sum and holds the
// finished result, with its flags, until the consumer accepts it.
module product_accumulator
    import product_acc_pkg::*;
#(
    parameter int n = 8,
    parameter int guard = 8,
    parameter int max_terms = 32,
    localparam int W = acc_width(n, guard),
    localparam int CW = count_width(max_terms)
) (
    input  logic           clk,
    input  logic           rst_n,
    input  logic           in_valid,
    output logic           in_ready,
    input  logic [2*n-1:0] in_product,
    input  logic           in_signed,
    input  logic           in_last,
    output logic           out_valid,
    input  logic           out_ready,
    output logic [W-1:0]   out_sum,
    output logic [CW-1:0]  out_count,
    output logic           out_overflow,
    output logic           out_mixed,
    output logic           out_truncated
);

    localparam logic [CW-1:0] MAX_COUNT = CW'(max_terms);

    state_t        state;
    state_t        state_next;
    logic [W-1:0]  acc;
    logic [CW-1:0] count;
    logic          grp_signed;
    logic          overflow;
    logic          mixed;
    logic          truncated;

    logic          accept;
    logic          start;
    logic          close;
    logic [CW-1:0] count_next;
    logic [W-1:0]  add_acc;
    logic          add_signed;
    logic [W-1:0]  add_sum;
    logic          add_ovf;

    product_acc_adder #(
        .n    (n),
        .guard(guard)
    ) u_adder (
        .acc      (add_acc),
        .product  (in_product),
        .is_signed(add_signed),
        .sum      (add_sum),
        .overflow (add_ovf)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // A beat accepted outside ACCUM (IDLE, or DONE while the result drains)
    // opens a fresh group, so the adder sees a zero accumulator then.
    always_comb begin
        in_ready   = (state != DONE) || out_ready;
        out_valid  = (state == DONE);
        accept     = in_valid && in_ready;
        start      = (state != ACCUM);
        count_next = start ? CW'(1) : count + CW'(1);
        close      = in_last || (count_next == MAX_COUNT);
        add_acc    = start ? '0 : acc;
        add_signed = start ? in_signed : grp_signed;
        state_next = state;
        if (accept) begin
            state_next = close ? DONE : ACCUM;
        end else if ((state == DONE) && out_ready) begin
            state_next = IDLE;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            acc        <= '0;
            count      <= '0;
            grp_signed <= 1'b0;
            overflow   <= 1'b0;
            mixed      <= 1'b0;
            truncated  <= 1'b0;
        end else if (accept) begin
            acc       <= add_sum;
            count     <= count_next;
            truncated <= close && !in_last;
            if (start) begin
                grp_signed <= in_signed;
                overflow   <= add_ovf;
                mixed      <= 1'b0;
            end else begin
                overflow <= overflow | add_ovf;
                mixed    <= mixed | (in_signed != grp_signed);
            end
        end
    end

    assign out_sum       = acc;
    assign out_count     = count;
    assign out_overflow  = overflow;
    assign out_mixed     = mixed;
    assign out_truncated = truncated;

endmodule

// File: tb/tb_product_accumulator.sv
// Directed-vector bench for product_accumulator at n=4, guard=4, max_terms=32.
module tb_product_accumulator;

    localparam int N = 4;
    localparam int GUARD = 4;
    localparam int MT = 32;
    localparam int W = 12;
    localparam int CW = 6;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          in_valid;
    logic          in_ready;
    logic [2*N-1:0] in_product;
    logic          in_signed;
    logic          in_last;
    logic          out_valid;
    logic          out_ready;
    logic [W-1:0]  out_sum;
    logic [CW-1:0] out_count;
    logic          out_overflow;
    logic          out_mixed;
    logic          out_truncated;

    int pass_count = 0;
    int check_count = 0;

    product_accumulator #(
        .n        (N),
        .guard    (GUARD),
        .max_terms(MT)
    ) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .in_valid     (in_valid),
        .in_ready     (in_ready),
        .in_product   (in_product),
        .in_signed    (in_signed),
        .in_last      (in_last),
        .out_valid    (out_valid),
        .out_ready    (out_ready),
        .out_sum      (out_sum),
        .out_count    (out_count),
        .out_overflow (out_overflow),
        .out_mixed    (out_mixed),
        .out_truncated(out_truncated)
    );

    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
        check_count++;
        if (actual !== expected) begin
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, actual, expected);
        end else begin
            pass_count++;
        end
    endtask

    // Drives one beat for a single cycle; returns #1 after the accepting edge.
    task automatic applyStimulus(input logic [7:0] product, input logic is_signed, input logic last);
        in_product = product;
        in_signed  = is_signed;
        in_last    = last;
        in_valid   = 1'b1;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        in_last  = 1'b0;
    endtask

    task automatic checkResult(input string tag, input logic [11:0] sum, input logic [5:0] count,
                               input logic ovf, input logic mix, input logic trunc);
        checkOutput({tag, "_valid"}, out_valid, 1);
        checkOutput({tag, "_sum"}, out_sum, sum);
        checkOutput({tag, "_count"}, out_count, count);
        checkOutput({tag, "_ovf"}, out_overflow, ovf);
        checkOutput({tag, "_mixed"}, out_mixed, mix);
        checkOutput({tag, "_trunc"}, out_truncated, trunc);
    endtask

    task automatic consumeResult(input string tag);
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        out_ready = 1'b0;
        checkOutput({tag, "_drained"}, out_valid, 0);
    endtask

    initial begin
        rst_n      = 1'b0;
        in_valid   = 1'b0;
        in_product = '0;
        in_signed  = 1'b0;
        in_last    = 1'b0;
        out_ready  = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        checkOutput("reset_valid", out_valid, 0);
        checkOutput("reset_in_ready", in_ready, 1);
        checkOutput("reset_sum", out_sum, 0);
        checkOutput("reset_count", out_count, 0);
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        // -15 + 4 under signed extension
        applyStimulus(8'hF1, 1'b1, 1'b0);
        checkOutput("signed_mid_valid", out_valid, 0);
        applyStimulus(8'h04, 1'b1, 1'b1);
        checkResult("signed_pair", 12'hFF5, 6'd2, 1'b0, 1'b0, 1'b0);
        consumeResult("signed_pair");

        // 241 + 4 under zero extension
        applyStimulus(8'hF1, 1'b0, 1'b0);
        applyStimulus(8'h04, 1'b0, 1'b1);
        checkResult("unsigned_pair", 12'h0F5, 6'd2, 1'b0, 1'b0, 1'b0);
        consumeResult("unsigned_pair");

        // 19 * 225 = 4275 wraps to 179
        for (int i = 0; i < 19; i++) begin
            applyStimulus(8'hE1, 1'b0, (i == 18));
        end
        checkResult("overflow", 12'h0B3, 6'd19, 1'b1, 1'b0, 1'b0);
        consumeResult("overflow");

        // Group closes itself on the 32nd beat
        for (int i = 0; i < 31; i++) begin
            applyStimulus(8'h01, 1'b0, 1'b0);
        end
        checkOutput("trunc_31_open", out_valid, 0);
        checkOutput("trunc_31_ready", in_ready, 1);
        applyStimulus(8'h01, 1'b0, 1'b0);
        checkResult("trunc", 12'h020, 6'd32, 1'b0, 1'b0, 1'b1);

        // Hold the result under backpressure
        for (int i = 0; i < 5; i++) begin
            @(posedge clk);
            #1;
            checkOutput("hold_in_ready", in_ready, 0);
            checkOutput("hold_valid", out_valid, 1);
            checkOutput("hold_sum", out_sum, 12'h020);
            checkOutput("hold_count", out_count, 6'd32);
        end

        // Drain and start a new group on the same edge
        out_ready = 1'b1;
        applyStimulus(8'h03, 1'b0, 1'b1);
        out_ready = 1'b0;
        checkResult("back_to_back", 12'h003, 6'd1, 1'b0, 1'b0, 1'b0);
        consumeResult("back_to_back");

        // Second beat disagrees with latched signedness; arithmetic stays signed
        applyStimulus(8'h01, 1'b1, 1'b0);
        applyStimulus(8'h02, 1'b0, 1'b1);
        checkResult("mixed", 12'h003, 6'd2, 1'b0, 1'b1, 1'b0);
        consumeResult("mixed");

        // Reset in the middle of a group
        applyStimulus(8'h05, 1'b0, 1'b0);
        rst_n = 1'b0;
        #1;
        checkOutput("midreset_valid", out_valid, 0);
        checkOutput("midreset_in_ready", in_ready, 1);
        checkOutput("midreset_count", out_count, 0);
        #2;
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        applyStimulus(8'h07, 1'b0, 1'b1);
        checkResult("post_reset", 12'h007, 6'd1, 1'b0, 1'b0, 1'b0);

        // Reset while a result is held
        rst_n = 1'b0;
        #1;
        checkOutput("donereset_valid", out_valid, 0);
        checkOutput("donereset_in_ready", in_ready, 1);
        #2;
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        checkOutput("donereset_stays_idle", out_valid, 0);

        $display("%0d/%0d checks passed", pass_count, check_count);
        $finish;
    end

endmodule
